ma_arbiter: RTL and testbench

MA_ARBITER -- requirements
Module: ma_arbiter

---
 rtl/ma_pkg.sv | 28 ++
 rtl/ma_arbiter_if.sv | 38 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/ma_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ma_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - shared types and constants for the MA compressor arbiter
package ma_pkg;

    localparam int MA_DATA_W = 80;
    localparam int MA_IDX_W  = 8;

    typedef enum logic [1:0] {
        NOP        = 2'd0,
        COMPRESS   = 2'd1,
        DECOMPRESS = 2'd2,
        INVALID    = 2'd3
    } ma_cmd_e;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    function automatic logic is_ma_cmd(ma_cmd_e c);
        return (c == COMPRESS) || (c == DECOMPRESS);
    endfunction

endpackage

// File: rtl/ma_arbiter_if.sv
// rtl/ma_arbiter_if.sv - requester and MA-side signal bundle for ma_arbiter
interface ma_arbiter_if #(
    parameter int DATA_W = 80,
    parameter int IDX_W  = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [3:0]          req_cmd;
    logic [2*DATA_W-1:0] req_data;
    logic [2*IDX_W-1:0]  req_idx;

    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_code;
    logic [IDX_W-1:0]    rsp_idx;
    logic [DATA_W-1:0]   rsp_data;

    logic [1:0]          ma_command;
    logic [DATA_W-1:0]   ma_data_in;
    logic [IDX_W-1:0]    ma_compressed_in;
    logic [IDX_W-1:0]    ma_compressed_out;
    logic [DATA_W-1:0]   ma_decompressed_out;
    logic [1:0]          ma_response;

    modport slave (
        input  req_valid, req_cmd, req_data, req_idx,
        input  ma_compressed_out, ma_decompressed_out, ma_response,
        output req_ready, rsp_valid, rsp_code, rsp_idx, rsp_data,
        output ma_command, ma_data_in, ma_compressed_in
    );

    modport master (
        output req_valid, req_cmd, req_data, req_idx,
        output ma_compressed_out, ma_decompressed_out, ma_response,
        input  req_ready, rsp_valid, rsp_code, rsp_idx, rsp_data,
        input  ma_command, ma_data_in, ma_compressed_in
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a registered priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_idx_o = prio_q;
        if (!req_i[prio_q]) begin
            gnt_idx_o = ~prio_q;
        end
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
        prio_d = prio_q;
        // The winner drops to lowest priority for the next arbitration
        if (advance_i && (|req_i)) begin
            prio_d = ~gnt_idx_o;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ma_arbiter.sv
// rtl/ma_arbiter.sv - two-requester front end for the shared MA compressor
// Defining MA_ARB_TIMEOUT_EN adds a WAIT-state timeout that answers with the error code.
module ma_arbiter
    import ma_pkg::*;
#(
    parameter int DATA_W  = MA_DATA_W,
    parameter int IDX_W   = MA_IDX_W,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    ma_arbiter_if.slave bus,
    output logic        busy
);

    arb_state_e        state_q, state_d;
    ma_cmd_e           cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              owner_q, owner_d;
    logic [1:0]        code_q, code_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              grant_idx;
    ma_cmd_e           sel_cmd;
    logic [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]  sel_idx;

    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    ma_cmd_e           ma_command;

`ifdef MA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int timeout_unused = TIMEOUT;
`endif

    // Arbitration is only open in IDLE and never while reset is held
    assign elig[0] = (state_q == ST_IDLE) && !reset && bus.req_valid[0]
                     && (bus.req_cmd[1:0] != 2'd0);
    assign elig[1] = (state_q == ST_IDLE) && !reset && bus.req_valid[1]
                     && (bus.req_cmd[3:2] != 2'd0);

    rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_i     (elig),
        .advance_i (|grant),
        .gnt_o     (grant),
        .gnt_idx_o (grant_idx)
    );

    assign sel_cmd  = ma_cmd_e'(grant_idx ? bus.req_cmd[3:2] : bus.req_cmd[1:0]);
    assign sel_data = grant_idx ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
    assign sel_idx  = grant_idx ? bus.req_idx[2*IDX_W-1:IDX_W] : bus.req_idx[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        idx_d      = idx_q;
        owner_d    = owner_q;
        code_d     = code_q;
        ridx_d     = ridx_q;
        rdata_d    = rdata_q;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        ma_command = NOP;
        busy       = 1'b1;
`ifdef MA_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (|grant) begin
                    req_ready = grant;
                    owner_d   = grant_idx;
                    cmd_d     = sel_cmd;
                    data_d    = sel_data;
                    idx_d     = sel_idx;
                    if (is_ma_cmd(sel_cmd)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Invalid command is answered locally; MA never sees it
                        code_d  = RSP_ERR;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                ma_command = cmd_q;
                state_d    = ST_WAIT;
`ifdef MA_ARB_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.ma_response != RSP_NONE) begin
                    code_d  = bus.ma_response;
                    ridx_d  = bus.ma_compressed_out;
                    rdata_d = bus.ma_decompressed_out;
                    state_d = ST_RESP;
                end
`ifdef MA_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    code_d  = RSP_ERR;
                    ridx_d  = '0;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= NOP;
            data_q  <= '0;
            idx_q   <= '0;
            owner_q <= 1'b0;
            code_q  <= '0;
            ridx_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            owner_q <= owner_d;
            code_q  <= code_d;
            ridx_q  <= ridx_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MA_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.req_ready        = req_ready;
    assign bus.rsp_valid        = rsp_valid;
    assign bus.rsp_code         = code_q;
    assign bus.rsp_idx          = ridx_q;
    assign bus.rsp_data         = rdata_q;
    assign bus.ma_command       = ma_command;
    assign bus.ma_data_in       = data_q;
    assign bus.ma_compressed_in = idx_q;

endmodule

// File: tb/tb_ma_arbiter.sv
// tb/tb_ma_arbiter.sv - scoreboard bench for ma_arbiter with a behavioural MA model
module tb_ma_arbiter;
    import ma_pkg::*;

    localparam int DW = 80;
    localparam int IW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    ma_arbiter_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    ma_arbiter #(.DATA_W(DW), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    logic          v0 = 1'b0, v1 = 1'b0;
    logic [1:0]    c0 = '0, c1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic [IW-1:0] x0 = '0, x1 = '0;
    logic [1:0]    ma_rsp = '0;
    logic [IW-1:0] ma_co = '0;
    logic [DW-1:0] ma_do = '0;

    assign bus.req_valid           = {v1, v0};
    assign bus.req_cmd             = {c1, c0};
    assign bus.req_data            = {d1, d0};
    assign bus.req_idx             = {x1, x0};
    assign bus.ma_response         = ma_rsp;
    assign bus.ma_compressed_out   = ma_co;
    assign bus.ma_decompressed_out = ma_do;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] f_comp(input logic [DW-1:0] d);
        return d[IW-1:0] ^ 8'h07;
    endfunction

    function automatic logic [DW-1:0] f_decomp(input logic [IW-1:0] x);
        return {10{x ^ 8'hA5}};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   resp_delay = 0;
    logic ma_mute = 1'b0;

    // MA model: answers one cycle into WAIT (plus resp_delay), for exactly one cycle
    logic [1:0]    mc;
    logic [DW-1:0] md;
    logic [IW-1:0] mx;
    always begin
        @(negedge clk);
        if (!reset && bus.ma_command != 2'd0 && !ma_mute) begin
            mc = bus.ma_command;
            md = bus.ma_data_in;
            mx = bus.ma_compressed_in;
            @(posedge clk); #1;
            repeat (resp_delay) begin @(posedge clk); #1; end
            if (mc == 2'd1) begin ma_rsp = 2'd1; ma_co = f_comp(md); ma_do = md; end
            else begin ma_rsp = 2'd2; ma_co = mx; ma_do = f_decomp(mx); end
            @(posedge clk); #1;
            ma_rsp = 2'd0; ma_co = '1; ma_do = '1;
        end
    end

    typedef struct {
        int            g;
        logic [1:0]    cmd;
        logic [DW-1:0] pd;
        logic [IW-1:0] px;
        logic [1:0]    code;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        int            acc;
        int            lat;
    } sb_t;

    sb_t sb[$];
    sb_t e, ne;
    logic [IW-1:0] exp_last_idx = '0;
    logic [DW-1:0] exp_last_data = '0;
    int n_rsp = 0, n_ma = 0, n_acc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rsp_valid != 2'b00) begin
                n_rsp++;
                if (sb.size() == 0) check("rsp_unexpected", bus.rsp_valid, 2'b00);
                else begin
                    e = sb.pop_front();
                    check("rsp_valid", bus.rsp_valid, (e.g == 1) ? 2'b10 : 2'b01);
                    check("rsp_code", bus.rsp_code, e.code);
                    check("rsp_idx", bus.rsp_idx, e.idx);
                    check("rsp_data", bus.rsp_data, e.data);
                    if (e.lat >= 0) check("rsp_latency", cyc - e.acc, e.lat);
                    else check("inv_latency_le2", (cyc - e.acc) <= 2, 1'b1);
                end
            end
            if (bus.ma_command != 2'b00) begin
                n_ma++;
                if (sb.size() == 0) check("ma_unexpected", bus.ma_command, 2'b00);
                else begin
                    check("ma_command", bus.ma_command, sb[0].cmd);
                    check("ma_latency", cyc - sb[0].acc, 1);
                    if (sb[0].cmd == 2'd1) check("ma_data_in", bus.ma_data_in, sb[0].pd);
                    else check("ma_compressed_in", bus.ma_compressed_in, sb[0].px);
                end
            end
            if ((bus.req_valid & bus.req_ready) != 2'b00) begin
                n_acc++;
                check("ready_onehot", $countones(bus.req_ready), 1);
                ne.g   = bus.req_ready[1] ? 1 : 0;
                ne.cmd = (ne.g == 1) ? c1 : c0;
                ne.pd  = (ne.g == 1) ? d1 : d0;
                ne.px  = (ne.g == 1) ? x1 : x0;
                ne.acc = cyc;
                if (ne.cmd == 2'd3) begin
                    ne.code = 2'd3; ne.idx = exp_last_idx; ne.data = exp_last_data; ne.lat = -1;
                end else if (ma_mute) begin
`ifdef MA_ARB_TIMEOUT_EN
                    ne.code = 2'd3; ne.idx = '0; ne.data = '0; ne.lat = TO + 2;
`else
                    ne.code = 2'd0; ne.idx = '0; ne.data = '0; ne.lat = -1;
`endif
                end else if (ne.cmd == 2'd1) begin
                    ne.code = 2'd1; ne.idx = f_comp(ne.pd); ne.data = ne.pd; ne.lat = 3 + resp_delay;
                end else begin
                    ne.code = 2'd2; ne.idx = ne.px; ne.data = f_decomp(ne.px); ne.lat = 3 + resp_delay;
                end
                exp_last_idx  = ne.idx;
                exp_last_data = ne.data;
                sb.push_back(ne);
            end
        end
    end

    task automatic send(input int g, input logic [1:0] c, input logic [DW-1:0] d,
                        input logic [IW-1:0] x, output int acc);
        @(posedge clk); #1;
        if (g == 0) begin v0 = 1'b1; c0 = c; d0 = d; x0 = x; end
        else begin v1 = 1'b1; c1 = c; d1 = d; x1 = x; end
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.req_ready[g]) begin acc = cyc; break; end
        end
        if (acc < 0) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        if (g == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        check("drain_timeout", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        exp_last_idx = '0;
        exp_last_data = '0;
        #1;
        check("rst_busy_now", busy, 1'b0);
        check("rst_ma_cmd_now", bus.ma_command, 2'b00);
        check("rst_rsp_valid_now", bus.rsp_valid, 2'b00);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int a0, a1, n0, got;
    int acc_t [8];

    initial begin
        #2 reset = 1'b1;
        v0 = 1'b1; c0 = 2'd1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_ma_command", bus.ma_command, 2'b00);
        check("rst_rsp_code", bus.rsp_code, 2'b00);
        check("rst_rsp_idx", bus.rsp_idx, 8'h00);
        check("rst_rsp_data", bus.rsp_data, 80'h0);
        check("rst_ma_data_in", bus.ma_data_in, 80'h0);
        v0 = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Single compress after reset, fixed 1-cycle MA response
        send(0, 2'd1, 80'h7, 8'h00, a0);
        @(negedge clk);
        check("t1_ma_command", bus.ma_command, 2'd1);
        @(negedge clk);
        @(negedge clk);
        check("t1_rsp_valid", bus.rsp_valid, 2'b01);
        check("t1_rsp_code", bus.rsp_code, 2'd1);
        check("t1_rsp_idx", bus.rsp_idx, 8'h00);
        drain(20);

        // NOP requests are never accepted
        @(posedge clk); #1 v1 = 1'b1; c1 = 2'd0;
        repeat (3) begin @(negedge clk); check("nop_ready", bus.req_ready, 2'b00); end
        @(posedge clk); #1 v1 = 1'b0;

        // Contention from reset priority, then again with req1 last-granted
        pulse_reset();
        fork
            send(0, 2'd1, 80'h1234, 8'h00, a0);
            send(1, 2'd2, 80'h0, 8'h01, a1);
        join
        check("rr_first_round", a1 - a0, 4);
        drain(20);
        fork
            send(0, 2'd1, 80'hBEEF_0042, 8'h00, a0);
            send(1, 2'd2, 80'h0, 8'h5C, a1);
        join
        check("rr_second_round", a1 - a0, 4);
        drain(20);

        // Invalid command is answered locally without touching MA
        n0 = n_ma;
        send(1, 2'd3, 80'h0, 8'h00, a1);
        drain(20);
        check("inv_no_ma_command", n_ma, n0);

        // Slow MA response holds WAIT
        resp_delay = 2;
        send(0, 2'd2, 80'h0, 8'h3C, a0);
        drain(30);
        resp_delay = 0;

        // Reset in WAIT drops the operation and restores req0 priority
        ma_mute = 1'b1;
        send(0, 2'd1, 80'hABC, 8'h00, a0);
        repeat (2) @(negedge clk);
        check("t5_busy_in_wait", busy, 1'b1);
        n0 = n_rsp;
        pulse_reset();
        ma_mute = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_rsp", n_rsp, n0);
        check("t5_code_cleared", bus.rsp_code, 2'b00);
        fork
            send(1, 2'd2, 80'h0, 8'h22, a1);
            send(0, 2'd1, 80'h99, 8'h00, a0);
        join
        check("t5_reset_prio", a1 - a0, 4);
        drain(30);
        check("t5_rsp_count", n_rsp, n0 + 2);

        // MA never answers
        ma_mute = 1'b1;
        send(0, 2'd1, 80'h55, 8'h00, a0);
`ifdef MA_ARB_TIMEOUT_EN
        drain(60);
`else
        repeat (40) @(negedge clk);
        check("no_timeout_busy", busy, 1'b1);
        pulse_reset();
`endif
        ma_mute = 1'b0;

        // Back-to-back stream from req0
        n0 = n_rsp;
        @(posedge clk); #1 v0 = 1'b1; c0 = 2'd1; d0 = 80'd100; x0 = '0;
        for (int k = 0; k < 8; k++) begin
            got = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (bus.req_ready[0]) begin got = 1; break; end
            end
            if (got == 0) begin check("stream_accept", 1'b0, 1'b1); break; end
            acc_t[k] = cyc;
            if (k > 0) check("stream_gap", acc_t[k] - acc_t[k-1], 4);
            @(posedge clk); #1 d0 = d0 + 1;
        end
        v0 = 1'b0;
        drain(30);
        check("stream_rsp_count", n_rsp, n0 + 8);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
